alarm_sequencer: RTL and testbench

//  Converts raw liquid-level comparator flags into a filtered, latched alarm code
//  for the alarm 7-segment decoder. Applies persistence filtering on LOW/HIGH,

---
 rtl/alarm_sequencer.sv | 107 ++++++++++
 tb/tb_alarm_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: filters level comparator flags into a latched alarm code,
// latches sensor faults until acknowledged, and generates the blink/blank
// control for the alarm display decoder.
module alarm_sequencer #(
  parameter int unsigned PERSIST_TICKS = 8,
  parameter int unsigned BLINK_TICKS   = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       level_low,
  input  logic       level_high,
  input  logic       sensor_fault,
  input  logic       ack,
  output logic [2:0] alarm_code,
  output logic       blank,
  output logic       alarm_active,
  output logic       changed
);

  localparam int unsigned PW = $clog2(PERSIST_TICKS + 1);
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
  localparam logic [PW-1:0] PERSIST_LAST = PW'(PERSIST_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);

  // State encoding is the decoder code itself, so alarm_code needs no decode.
  typedef enum logic [2:0] {
    S_OK   = 3'b000,
    S_LOW  = 3'b001,
    S_HIGH = 3'b010,
    S_ERR  = 3'b100
  } state_t;

  state_t          state_q, state_nxt;
  state_t          cand, prev_cand;
  logic [PW-1:0]   persist_cnt, persist_nxt;
  logic [BW-1:0]   blink_cnt, blink_nxt;
  logic            blank_nxt;

  assign alarm_code = state_q;

  // Registers: state, filter history, counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_OK;
      prev_cand    <= S_OK;
      persist_cnt  <= '0;
      blink_cnt    <= '0;
      blank        <= 1'b0;
      alarm_active <= 1'b0;
      changed      <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      prev_cand    <= cand;
      persist_cnt  <= persist_nxt;
      blink_cnt    <= blink_nxt;
      blank        <= blank_nxt;
      alarm_active <= (state_nxt != S_OK);
      changed      <= (state_nxt != state_q);
    end
  end

  // Candidate decode, persistence filter / fault latch, and blink generation.
  always_comb begin
    cand        = S_OK;
    state_nxt   = state_q;
    persist_nxt = persist_cnt;
    blink_nxt   = blink_cnt;
    blank_nxt   = blank;

    if (sensor_fault || (level_low && level_high)) cand = S_ERR;
    else if (level_low)                            cand = S_LOW;
    else if (level_high)                           cand = S_HIGH;

    if (cand == S_ERR) begin
      // Fault wins over everything, including a coincident tick.
      state_nxt   = S_ERR;
      persist_nxt = '0;
    end else if (state_q == S_ERR) begin
      if (ack) state_nxt = S_OK;
      persist_nxt = '0;
    end else if ((cand == state_q) || (cand != prev_cand)) begin
      persist_nxt = '0;
    end else if (tick) begin
      if (persist_cnt == PERSIST_LAST) begin
        state_nxt   = cand;
        persist_nxt = '0;
      end else begin
        persist_nxt = persist_cnt + PW'(1);
      end
    end

    // Any state change (or sitting in OK) restarts the blink phase unblanked.
    if ((state_nxt != state_q) || (state_nxt == S_OK)) begin
      blank_nxt = 1'b0;
      blink_nxt = '0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blank_nxt = ~blank;
        blink_nxt = '0;
      end else begin
        blink_nxt = blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed testbench for alarm_sequencer (PERSIST_TICKS=8, BLINK_TICKS=3).
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       reset, tick, level_low, level_high, sensor_fault, ack;
  logic [2:0] alarm_code;
  logic       blank, alarm_active, changed;

  int checks = 0;
  int errors = 0;

  alarm_sequencer #(.PERSIST_TICKS(8), .BLINK_TICKS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .level_low    (level_low),
    .level_high   (level_high),
    .sensor_fault (sensor_fault),
    .ack          (ack),
    .alarm_code   (alarm_code),
    .blank        (blank),
    .alarm_active (alarm_active),
    .changed      (changed)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic apply_reset();
    {tick, level_low, level_high, sensor_fault, ack} = '0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      level_low = i[0]; level_high = i[1]; sensor_fault = i[2];
      ack = ~i[0]; tick = 1'b1;
      cyc();
      checks++;
      if ({alarm_code, blank, changed, alarm_active} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold i=%0d got code=%b blank=%b chg=%b act=%b exp all 0",
                 i, alarm_code, blank, changed, alarm_active);
      end
    end
    apply_reset();
  endtask

  task automatic test_persist();
    apply_reset();
    level_low = 1'b1;
    cyc();
    ticks(7);
    checks++;
    if (alarm_code !== 3'b000) begin
      errors++; $display("FAIL persist_7 code=%b exp=000", alarm_code);
    end
    ticks(1);
    checks++;
    if ({alarm_code, changed, alarm_active, blank} !== 6'b001_1_1_0) begin
      errors++;
      $display("FAIL persist_8 code=%b chg=%b act=%b blank=%b exp 001 1 1 0",
               alarm_code, changed, alarm_active, blank);
    end
    cyc();
    checks++;
    if ({alarm_code, changed} !== 4'b001_0) begin
      errors++; $display("FAIL persist_pulse code=%b chg=%b exp 001 0", alarm_code, changed);
    end
    // Back to OK also needs 8 stable ticks.
    level_low = 1'b0;
    cyc();
    ticks(7);
    checks++;
    if (alarm_code !== 3'b001) begin
      errors++; $display("FAIL persist_ok7 code=%b exp=001", alarm_code);
    end
    ticks(1);
    checks++;
    if ({alarm_code, changed, alarm_active, blank} !== 6'b000_1_0_0) begin
      errors++;
      $display("FAIL persist_ok8 code=%b chg=%b act=%b blank=%b exp 000 1 0 0",
               alarm_code, changed, alarm_active, blank);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    level_low = 1'b1;
    cyc();
    ticks(5);
    level_low = 1'b0;            // drop for one tick
    ticks(1);
    level_low = 1'b1;            // re-assert; tick in the unstable cycle must not count
    ticks(1);
    ticks(7);
    checks++;
    if (alarm_code !== 3'b000) begin
      errors++; $display("FAIL glitch_7 code=%b exp=000", alarm_code);
    end
    ticks(1);
    checks++;
    if ({alarm_code, changed} !== 4'b001_1) begin
      errors++; $display("FAIL glitch_8 code=%b chg=%b exp 001 1", alarm_code, changed);
    end
    level_low = 1'b0;
  endtask

  task automatic test_fault_latch();
    apply_reset();
    sensor_fault = 1'b1;
    cyc();
    checks++;
    if ({alarm_code, changed, alarm_active} !== 5'b100_1_1) begin
      errors++;
      $display("FAIL fault_entry code=%b chg=%b act=%b exp 100 1 1", alarm_code, changed, alarm_active);
    end
    sensor_fault = 1'b0;
    ticks(3);
    checks++;
    if ({alarm_code, changed} !== 4'b100_0) begin
      errors++; $display("FAIL fault_latched code=%b chg=%b exp 100 0", alarm_code, changed);
    end
    ack = 1'b1;
    cyc();
    checks++;
    if ({alarm_code, changed, alarm_active, blank} !== 6'b000_1_0_0) begin
      errors++;
      $display("FAIL fault_ack code=%b chg=%b act=%b blank=%b exp 000 1 0 0",
               alarm_code, changed, alarm_active, blank);
    end
    sensor_fault = 1'b1;
    cyc();
    cyc();
    checks++;
    if (alarm_code !== 3'b100) begin
      errors++; $display("FAIL fault_ack_held code=%b exp=100", alarm_code);
    end
    sensor_fault = 1'b0;
    cyc();
    checks++;
    if (alarm_code !== 3'b000) begin
      errors++; $display("FAIL fault_ack_release code=%b exp=000", alarm_code);
    end
    ack = 1'b0;
  endtask

  task automatic test_error_tick_priority();
    apply_reset();
    level_low = 1'b1;
    cyc();
    ticks(8);
    sensor_fault = 1'b1;
    ticks(1);                    // fault and tick together
    checks++;
    if ({alarm_code, blank} !== 4'b100_0) begin
      errors++; $display("FAIL err_tick_entry code=%b blank=%b exp 100 0", alarm_code, blank);
    end
    ticks(2);
    checks++;
    if (blank !== 1'b0) begin
      errors++; $display("FAIL err_tick_nocount blank=%b exp=0", blank);
    end
    ticks(1);
    checks++;
    if (blank !== 1'b1) begin
      errors++; $display("FAIL err_blink blank=%b exp=1", blank);
    end
    {level_low, sensor_fault} = '0;
  endtask

  task automatic test_blink();
    apply_reset();
    level_high = 1'b1;
    cyc();
    ticks(8);
    checks++;
    if ({alarm_code, blank} !== 4'b010_0) begin
      errors++; $display("FAIL blink_high code=%b blank=%b exp 010 0", alarm_code, blank);
    end
    ticks(2);
    checks++;
    if (blank !== 1'b0) begin
      errors++; $display("FAIL blink_t2 blank=%b exp=0", blank);
    end
    ticks(1);
    checks++;
    if (blank !== 1'b1) begin
      errors++; $display("FAIL blink_t3 blank=%b exp=1", blank);
    end
    ticks(2);
    checks++;
    if (blank !== 1'b1) begin
      errors++; $display("FAIL blink_t5 blank=%b exp=1", blank);
    end
    ticks(1);
    checks++;
    if (blank !== 1'b0) begin
      errors++; $display("FAIL blink_t6 blank=%b exp=0", blank);
    end
    ticks(3);                    // blank=1, blink count 0
    level_high = 1'b0;
    cyc();
    ticks(7);                    // blink toggles at filter ticks 3 and 6 -> blank=1
    checks++;
    if ({alarm_code, blank} !== 4'b010_1) begin
      errors++; $display("FAIL blink_pre_ok code=%b blank=%b exp 010 1", alarm_code, blank);
    end
    ticks(1);
    checks++;
    if ({alarm_code, blank, changed} !== 5'b000_0_1) begin
      errors++;
      $display("FAIL blink_ok code=%b blank=%b chg=%b exp 000 0 1", alarm_code, blank, changed);
    end
  endtask

  task automatic test_reset_mid_blink();
    apply_reset();
    level_low = 1'b1;
    level_high = 1'b1;
    cyc();
    checks++;
    if (alarm_code !== 3'b100) begin
      errors++; $display("FAIL both_err code=%b exp=100", alarm_code);
    end
    ticks(3);
    checks++;
    if (blank !== 1'b1) begin
      errors++; $display("FAIL both_blink blank=%b exp=1", blank);
    end
    ticks(1);
    reset = 1'b1;
    #2;
    checks++;
    if ({alarm_code, blank, changed, alarm_active} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset code=%b blank=%b chg=%b act=%b exp all 0",
               alarm_code, blank, changed, alarm_active);
    end
    {level_low, level_high} = '0;
    cyc();
    reset = 1'b0;
    cyc();
    checks++;
    if ({alarm_code, blank, changed, alarm_active} !== 6'b0) begin
      errors++;
      $display("FAIL post_reset code=%b blank=%b chg=%b act=%b exp all 0",
               alarm_code, blank, changed, alarm_active);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    {reset, tick, level_low, level_high, sensor_fault, ack} = '0;
    test_reset();
    test_persist();
    test_glitch();
    test_fault_latch();
    test_error_tick_priority();
    test_blink();
    test_reset_mid_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
